// File: rtl/blink_pkg.sv
// Shared types and constants for the LED blink sequencer: FSM states,
// the LFSR feedback taps and the default LFSR seed.
package blink_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GAP,
      ST_SHOW,
      ST_DONE
   } blink_seq_state_t;

   // Feedback taps b15, b13, b12, b10
   localparam logic [15:0] LFSR_TAPS         = 16'hB400;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

   // An all-zero seed would lock the LFSR, so fall back to the default.
   function automatic logic [15:0] lfsr_seed_fix(input logic [15:0] seed);
      return (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
   endfunction

endpackage

// File: rtl/blink_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, shifting left every cycle out of reset.
module blink_lfsr16
   import blink_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] q
);

   localparam logic [15:0] SEED_EFF = lfsr_seed_fix(SEED);

   logic [15:0] lfsr_q;

   // NOTE: sequential state is written only with non-blocking assignments so
   // every register samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr_q <= SEED_EFF;
      end else begin
         lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
      end
   end

   assign q = lfsr_q;

endmodule

// File: rtl/blink_led_sequencer.sv
// Reaction-game LED sequencer: gap, random one-hot LED window, hit/miss scoring.
// Define BLINK_SPEEDUP_EN to shorten the LED window after every hit.
module blink_led_sequencer
   import blink_pkg::*;
#(
   parameter int unsigned ON_CYCLES  = 50_000_000,
   parameter int unsigned GAP_CYCLES = 25_000_000,
   parameter int unsigned NUM_ROUNDS = 20,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        hit,
   output logic [15:0] led,
   output logic        busy,
   output logic        hit_pulse,
   output logic        miss_pulse,
   output logic        done,
   output logic [7:0]  round_cnt
);

   localparam logic [31:0] ON_LEN   = 32'(ON_CYCLES);
   localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES - 1);
   localparam logic [7:0]  ROUNDS   = 8'(NUM_ROUNDS);

   blink_seq_state_t state_q, state_d;
   logic [15:0] led_q, led_d;
   logic        busy_q, busy_d;
   logic        hit_pulse_q, hit_pulse_d;
   logic        miss_pulse_q, miss_pulse_d;
   logic        done_q, done_d;
   logic [7:0]  round_q, round_d;
   logic [31:0] timer_q, timer_d;
   logic [31:0] on_len_q, on_len_d;
   logic [7:0]  round_inc;

   logic [15:0] lfsr;
   logic        lfsr_unused;

   blink_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .q     (lfsr)
   );

   // Only the low nibble picks the LED; the rest of the LFSR is internal state.
   assign lfsr_unused = ^lfsr[15:4];
   assign round_inc   = round_q + 8'd1;

`ifdef BLINK_SPEEDUP_EN
   localparam logic [31:0] ON_STEP  = 32'(ON_CYCLES >> 3);
   localparam logic [31:0] ON_FLOOR = 32'(ON_CYCLES >> 2);

   logic [31:0] on_len_fast;
   assign on_len_fast = (on_len_q >= ON_FLOOR + ON_STEP) ? on_len_q - ON_STEP : ON_FLOOR;
`endif

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      led_d        = led_q;
      busy_d       = busy_q;
      hit_pulse_d  = 1'b0;
      miss_pulse_d = 1'b0;
      done_d       = 1'b0;
      round_d      = round_q;
      timer_d      = timer_q;
      on_len_d     = on_len_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_GAP;
               round_d  = 8'd0;
               busy_d   = 1'b1;
               timer_d  = GAP_LOAD;
               on_len_d = ON_LEN;
            end
         end
         ST_GAP: begin
            led_d = 16'h0000;
            if (timer_q == 32'd0) begin
               state_d = ST_SHOW;
               led_d   = 16'h0001 << lfsr[3:0];
               timer_d = on_len_q - 32'd1;
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         ST_SHOW: begin
            // A hit on the last window cycle still counts as a hit.
            if (hit || (timer_q == 32'd0)) begin
               hit_pulse_d  = hit;
               miss_pulse_d = !hit;
               led_d        = 16'h0000;
               round_d      = round_inc;
`ifdef BLINK_SPEEDUP_EN
               if (hit) on_len_d = on_len_fast;
`endif
               if (round_inc == ROUNDS) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_GAP;
                  timer_d = GAP_LOAD;
               end
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         led_q        <= 16'h0000;
         busy_q       <= 1'b0;
         hit_pulse_q  <= 1'b0;
         miss_pulse_q <= 1'b0;
         done_q       <= 1'b0;
         round_q      <= 8'd0;
         timer_q      <= 32'd0;
         on_len_q     <= ON_LEN;
      end else begin
         state_q      <= state_d;
         led_q        <= led_d;
         busy_q       <= busy_d;
         hit_pulse_q  <= hit_pulse_d;
         miss_pulse_q <= miss_pulse_d;
         done_q       <= done_d;
         round_q      <= round_d;
         timer_q      <= timer_d;
         on_len_q     <= on_len_d;
      end
   end

   assign led        = led_q;
   assign busy       = busy_q;
   assign hit_pulse  = hit_pulse_q;
   assign miss_pulse = miss_pulse_q;
   assign done       = done_q;
   assign round_cnt  = round_q;

endmodule

// File: doc/blink_led_sequencer.md
BLINK_LED_SEQUENCER -- requirements
Module: blink_led_sequencer

Interface
REQ-001 SHALL have parameter ON_CYCLES, default 50_000_000, giving the initial LED-on window in clk cycles (at least 2).
REQ-002 SHALL have parameter GAP_CYCLES, default 25_000_000, giving the all-LEDs-off gap between rounds in cycles (at least 2).
REQ-003 SHALL have parameter NUM_ROUNDS, default 20, giving the rounds per game (1..255).
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, giving the LFSR reset value; a value of 0 SHALL be replaced by 16'hACE1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: begins a game; sampled only in IDLE.
REQ-008 SHALL have port hit, input, 1 bit: registered "LED and switch both on" flag from the downstream validity checker.
REQ-009 SHALL have port led, output, 16 bits: one-hot lit LED, or all zero.
REQ-010 SHALL have port busy, output, 1 bit: high from leaving IDLE until DONE is entered.
REQ-011 SHALL have port hit_pulse, output, 1 bit: one-cycle pulse when a round is won.
REQ-012 SHALL have port miss_pulse, output, 1 bit: one-cycle pulse when a round times out.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at game end.
REQ-014 SHALL have port round_cnt, output, 8 bits: rounds completed in the current game.

Function
REQ-015 SHALL implement a state machine with states IDLE, GAP, SHOW and DONE; all outputs SHALL be registered.
REQ-016 SHALL run a 16-bit Fibonacci LFSR that shifts left every cycle out of reset, with new bit0 = b15^b13^b12^b10.
REQ-017 In IDLE with start=1, SHALL go to GAP: round_cnt<=0, busy<=1, timer<=GAP_CYCLES-1, on_len<=ON_CYCLES.
REQ-018 In GAP, SHALL hold led=0, ignore hit, and decrement the timer; at timer 0, SHALL go to SHOW with led<=1<<lfsr[3:0] and timer<=on_len-1.
REQ-019 In SHOW with hit=1, SHALL set hit_pulse for one cycle, led<=0, and round_cnt+1.
REQ-020 In SHOW with hit=0 and timer 0, SHALL set miss_pulse for one cycle, led<=0, and round_cnt+1.
REQ-021 If hit=1 and the timer is 0 in the same cycle, hit SHALL win: hit_pulse only, no miss_pulse.
REQ-022 After a round ends, SHALL go to DONE if the new round_cnt equals NUM_ROUNDS; otherwise SHALL go to GAP with timer<=GAP_CYCLES-1.
REQ-023 In DONE, SHALL assert done for one cycle with busy=0, then go to IDLE; round_cnt SHALL hold until the next start.
REQ-024 SHALL ignore start outside IDLE.
REQ-025 SHALL ignore hit in IDLE, GAP and DONE; this absorbs the one-cycle lag of hit after led clears.
REQ-026 round_cnt SHALL never exceed NUM_ROUNDS and never wrap.

Reset
REQ-027 While rst_n=0 at a clock edge, SHALL set: state=IDLE, led=0, busy=0, hit_pulse=0, miss_pulse=0, done=0, round_cnt=0, timer=0, on_len=ON_CYCLES, lfsr=seed.
REQ-028 Reset mid-game SHALL abandon the game immediately with no done, hit_pulse or miss_pulse.

Configuration
REQ-029 With macro BLINK_SPEEDUP_EN defined, each hit SHALL set on_len <= max(on_len - (ON_CYCLES>>3), ON_CYCLES>>2), taking effect from the next SHOW.
REQ-030 Without BLINK_SPEEDUP_EN, on_len SHALL stay ON_CYCLES and the subtract/compare logic SHALL be absent.

Structure
REQ-031 Package blink_pkg SHALL hold the state enum blink_seq_state_t, the LFSR tap constant, and the default seed constant.
REQ-032 The LFSR SHALL be sub-module blink_lfsr16 (ports clk, rst_n, q[15:0]); the timer and state machine stay in the top level.

Verification
Parameters for these tests: ON_CYCLES=8, GAP_CYCLES=4, NUM_ROUNDS=3, LFSR_SEED=16'hACE1.
REQ-033 Reset then start at cycle 0 -> busy=1 next cycle; led goes one-hot exactly 4 cycles after entering GAP, at bit index lfsr[3:0] matching a reference model.
REQ-034 No hit for 3 rounds -> each led held 8 cycles, then 3 miss_pulse, round_cnt=3, done for one cycle, busy=0, led=0.
REQ-035 hit=1 on the 3rd SHOW cycle -> hit_pulse next edge, led=0, round_cnt+1; hit held high into GAP -> no second hit_pulse.
REQ-036 hit=1 in the final SHOW cycle (timer 0) -> hit_pulse=1 and miss_pulse=0.
REQ-037 With BLINK_SPEEDUP_EN: consecutive hits -> on windows of 8, 7, 6 cycles, clamped at 2; without the macro the window is always 8.
REQ-038 rst_n=0 during SHOW and start pulsed during GAP -> after reset all outputs are 0 and the state is IDLE; the mid-game start has no effect.
